// File: rtl/x2_preimage_search.sv
// Sequential preimage search over the 10-in/7-out x2 function: sweeps all candidates, one per cycle.
// Optional macro X2_PREIMAGE_COUNT_EN: full sweep that counts every match instead of stopping at the first.
module x2_preimage_search #(
    parameter int SCAN_LAST = 1023,
    parameter int CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [6:0]       target,
    input  logic [6:0]       care_mask,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [9:0]       match_vec,
    output logic [CNT_W-1:0] match_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [9:0]       SCAN_LAST_V = 10'(SCAN_LAST);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [9:0]       cand_reg;
    logic [6:0]       target_reg;
    logic [6:0]       mask_reg;
    logic             found_reg;
    logic [9:0]       match_vec_reg;
    logic [CNT_W-1:0] match_count_reg;

    logic [6:0]       f_out;
    logic             cand_hit;
    logic             cand_last;

    // Reference copy of x2; bit order {k,l,m,n,o,p,q} out, {a..j} in.
    function automatic logic [6:0] x2_eval(input logic [9:0] v);
        logic a, b, c, d, e, f, g, h, i, j;
        logic t7, t9, k, l, m, n, o, p, q;
        {a, b, c, d, e, f, g, h, i, j} = v;
        t7 = (j & i & ~h & f) | ~g;
        t9 = a | b;
        k  = j | ~i | ~h;
        l  = (j ^ h) | i;
        m  = ~j & ~i & ~h;
        n  = t9 | m | j | h | c;
        o  = (j & i) | ~h | ~g;
        p  = (~t9 & l & k & h & c) | (~t9 & l & ~i & c) | (~k & ~e & d) | (~j & ~i) | t7;
        q  = (~t9 & o & h & ~c) | (~k & e & d) | t7 | ~l;
        return {k, l, m, n, o, p, q};
    endfunction

    assign f_out     = x2_eval(cand_reg);
    assign cand_hit  = (((f_out ^ target_reg) & mask_reg) == 7'd0);
    assign cand_last = (cand_reg == SCAN_LAST_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                // abort takes priority over a match in the same cycle
                if (abort) begin
                    state_next = IDLE;
`ifdef X2_PREIMAGE_COUNT_EN
                end else if (cand_last) begin
                    state_next = FIN;
`else
                end else if (cand_hit || cand_last) begin
                    state_next = FIN;
`endif
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            SCAN:    busy = 1'b1;
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_reg        <= 10'd0;
            target_reg      <= 7'd0;
            mask_reg        <= 7'd0;
            found_reg       <= 1'b0;
            match_vec_reg   <= 10'd0;
            match_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        target_reg      <= target;
                        mask_reg        <= care_mask;
                        found_reg       <= 1'b0;
                        match_vec_reg   <= 10'd0;
                        match_count_reg <= '0;
                        cand_reg        <= 10'd0;
                    end
                end
                SCAN: begin
                    if (!abort) begin
                        if (cand_hit) begin
                            // match_vec keeps the lowest matching index
                            if (!found_reg) begin
                                match_vec_reg <= cand_reg;
                            end
                            found_reg <= 1'b1;
`ifdef X2_PREIMAGE_COUNT_EN
                            if (match_count_reg != CNT_MAX) begin
                                match_count_reg <= match_count_reg + CNT_ONE;
                            end
`else
                            match_count_reg <= CNT_ONE;
`endif
                        end
                        if (!cand_last) begin
                            cand_reg <= cand_reg + 10'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign found       = found_reg;
    assign match_vec   = match_vec_reg;
    assign match_count = match_count_reg;

endmodule

// File: tb/tb_x2_preimage_search.sv
// Self-checking bench for x2_preimage_search: vector table plus reset/abort/start-ignore sequences.
// Expectations follow X2_PREIMAGE_COUNT_EN when it is defined.
module tb_x2_preimage_search;

    localparam int CNT_W = 11;

`ifdef X2_PREIMAGE_COUNT_EN
    localparam bit CNT_MODE = 1'b1;
`else
    localparam bit CNT_MODE = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [6:0]       target;
    logic [6:0]       care_mask;
    logic             busy;
    logic             done;
    logic             found;
    logic [9:0]       match_vec;
    logic [CNT_W-1:0] match_count;

    x2_preimage_search #(.SCAN_LAST(1023), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .target      (target),
        .care_mask   (care_mask),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .match_vec   (match_vec),
        .match_count (match_count)
    );

    typedef struct {
        logic [6:0] target;
        logic [6:0] mask;
        logic       exp_found;
        logic [9:0] exp_vec;
        int         exp_count;
        int         exp_lat;   // edges from the start-sampling edge to done visible
    } vec_t;

    typedef struct {
        vec_t v;
        int   start_cyc;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   cyc;
    int   n_checks;
    int   n_errs;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Wait for done, pop the scoreboard, compare; optionally poke start during FIN.
    task automatic wait_done(input bit poke_fin);
        int  k;
        bit  got;
        sb_t e;
        k   = 0;
        got = 1'b0;
        while (!got && k < 3000) begin
            if (done) got = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        if (!got) begin
            check("done_timeout", 0, 1);
            return;
        end
        check("latency", cyc - e.start_cyc, e.v.exp_lat);
        check("found", int'(found), int'(e.v.exp_found));
        check("match_vec", int'(match_vec), int'(e.v.exp_vec));
        check("match_count", int'(match_count), e.v.exp_count);
        check("busy_in_fin", int'(busy), 0);
        $display("txn target=%02h mask=%02h found=%0d vec=%0d count=%0d lat=%0d",
                 e.v.target, e.v.mask, found, match_vec, match_count, cyc - e.start_cyc);
        if (poke_fin) begin
            start     = 1'b1;
            target    = 7'h5F;
            care_mask = 7'h7F;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse_width", int'(done), 0);
        check("busy_after_fin", int'(busy), 0);
    endtask

    task automatic run_vec(input vec_t v, input bit poke_mid, input bit poke_fin);
        sb_t e;
        @(negedge clk);
        start     = 1'b1;
        target    = v.target;
        care_mask = v.mask;
        e.v         = v;
        e.start_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start     = 1'b0;
        target    = ~v.target;
        care_mask = ~v.mask;
        if (poke_mid && v.exp_lat > 3) begin
            @(negedge clk);
            check("busy_mid_scan", int'(busy), 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(poke_fin);
    endtask

    initial begin
        vec_t v;
        int   n_done;
        cyc       = 0;
        n_checks  = 0;
        n_errs    = 0;
        rst_n     = 1'b0;
        abort     = 1'b0;
        // Reset held with start high: scan must begin right after release.
        start     = 1'b1;
        target    = 7'h55;
        care_mask = 7'h00;

        if (CNT_MODE) begin
            vecs.push_back('{7'h00, 7'h40, 1'b1, 10'd6,  128,  1024});
            vecs.push_back('{7'h00, 7'h60, 1'b0, 10'd0,  0,    1024});
            vecs.push_back('{7'h00, 7'h20, 1'b1, 10'd0,  256,  1024});
            vecs.push_back('{7'h00, 7'h04, 1'b1, 10'd12, 192,  1024});
            vecs.push_back('{7'h10, 7'h10, 1'b1, 10'd0,  128,  1024});
            vecs.push_back('{7'h55, 7'h00, 1'b1, 10'd0,  1024, 1024});
        end else begin
            vecs.push_back('{7'h5F, 7'h7F, 1'b1, 10'd0,  1, 1});
            vecs.push_back('{7'h00, 7'h40, 1'b1, 10'd6,  1, 7});
            vecs.push_back('{7'h00, 7'h60, 1'b0, 10'd0,  0, 1024});
            vecs.push_back('{7'h00, 7'h20, 1'b1, 10'd0,  1, 1});
            vecs.push_back('{7'h00, 7'h04, 1'b1, 10'd12, 1, 13});
            vecs.push_back('{7'h00, 7'h01, 1'b1, 10'd9,  1, 10});
            vecs.push_back('{7'h10, 7'h10, 1'b1, 10'd0,  1, 1});
            vecs.push_back('{7'h55, 7'h00, 1'b1, 10'd0,  1, 1});
        end

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_found", int'(found), 0);
        check("rst_match_vec", int'(match_vec), 0);
        check("rst_match_count", int'(match_count), 0);

        begin
            sb_t e;
            e.v         = vecs[vecs.size() - 1];
            e.start_cyc = cyc + 1;
            sb.push_back(e);
        end
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_release", int'(busy), 1);
        wait_done(1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], 1'b1, 1'b1);
        end

        // Abort mid-scan of an unreachable target: no done, busy drops next edge.
        @(negedge clk);
        start     = 1'b1;
        target    = 7'h00;
        care_mask = 7'h60;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_abort", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("busy_after_abort", int'(busy), 0);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("no_done_after_abort", n_done, 0);
        check("found_after_abort", int'(found), 0);
        $display("txn abort target=00 mask=60 busy=%0d dones=%0d", busy, n_done);
        run_vec(vecs[0], 1'b0, 1'b0);

        // Asynchronous reset in the middle of a scan.
        v = CNT_MODE ? vecs[2] : vecs[2];
        @(negedge clk);
        start     = 1'b1;
        target    = 7'h00;
        care_mask = CNT_MODE ? 7'h20 : 7'h60;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_before_rst", int'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_found", int'(found), 0);
        check("async_rst_match_vec", int'(match_vec), 0);
        check("async_rst_match_count", int'(match_count), 0);
        $display("txn async reset mid-scan busy=%0d found=%0d count=%0d", busy, found, match_count);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(v, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/x2_preimage_search.md
Name: x2_preimage_search

Overview:
- Sequential inverse of the 10-in/7-out x2 logic function, used for approximate-synthesis error analysis.
- Given a 7-bit target output and a care mask, it sweeps all 1024 input vectors through an embedded copy of x2, one per cycle.
- It reports the first input vector whose output matches on all cared bits (the preimage), or that none exists.
- Sits beside the approximated x2 netlist in the evaluation harness.

Parameters:
- SCAN_LAST, 1023: last candidate index swept (0..1023); lowered only for bench speed-up.
- CNT_W, 11: width of match_count (must hold SCAN_LAST+1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a new scan; sampled only in IDLE
- abort  in  1  cancel the scan in progress; return to IDLE, no done
- target  in  7  desired output, bit6=k .. bit0=q; captured on start
- care_mask  in  7  1 = bit compared; captured on start
- busy  out  1  high in SCAN
- done  out  1  one-cycle pulse at scan end
- found  out  1  at least one match; held until next accepted start
- match_vec  out  10  first matching candidate, bit9=a .. bit0=j; held
- match_count  out  CNT_W  number of matches (see Optional Feature); held

Behaviour:
- Embedded function, combinational on candidate c:
  - t7 = (j&i&~h&f) | ~g
  - t9 = a|b
  - k = j|~i|~h
  - l = (j^h)|i
  - m = ~j&~i&~h
  - n = t9|m|j|h|c
  - o = (j&i)|~h|~g
  - p = (~t9&l&k&h&c) | (~t9&l&~i&c) | (~k&~e&d) | (~j&~i) | t7
  - q = (~t9&o&h&~c) | (~k&e&d) | t7 | ~l
- Match condition: ((F(c) ^ target_q) & mask_q) == 0. A mask of 0 matches every candidate.
- Reset values: busy=0, done=0, found=0, match_vec=0, match_count=0. State is IDLE, candidate counter is 0.
- FSM states IDLE, SCAN, FIN:
  - IDLE: on start, capture target and mask, clear found/match_vec/match_count, set candidate=0, go to SCAN.
  - SCAN: evaluate one candidate per cycle.
    - On a match in first-match mode: latch match_vec and set found=1, match_count=1, go to FIN.
    - Otherwise, if candidate==SCAN_LAST, go to FIN. Else increment the candidate.
  - FIN: done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge T. Candidate n is evaluated in cycle T+1+n. done is high in the cycle after the terminating evaluation.
  - First match at index n: done during cycle T+n+2.
  - No match: done during cycle T+SCAN_LAST+2.
- start while busy or in FIN: ignored. target/mask changes mid-scan have no effect.
- abort in SCAN: go to IDLE next edge with no done pulse. found/match_vec/match_count keep their partial values. abort outside SCAN is ignored.
- abort and a match in the same cycle: abort wins.
- The candidate counter never wraps past SCAN_LAST.
- rst_n low at any time: immediate return to reset values; a scan in progress is lost.

Optional Feature:
- Macro: X2_PREIMAGE_COUNT_EN.
- Defined: the scan never stops early. Every candidate 0..SCAN_LAST is evaluated, and match_count accumulates all matches (saturating at 2^CNT_W-1). match_vec holds the lowest matching index. done arrives at T+SCAN_LAST+2 regardless of matches.
- Undefined: first-match mode as above. match_count is only ever 0 or 1.

Test Plan:
- Reset with start=1 held, then release rst_n: all outputs 0. Scan begins on the first clk edge after release.
- start, target=7'h5F, mask=7'h7F: done at T+2, found=1, match_vec=10'd0, match_count=1.
- start, target=7'h00, mask=7'h40 (k=0): found=1, match_vec=10'd6, done at T+8.
- start, target=7'h00, mask=7'h60 (k=0, l=0; unreachable): done at T+1025, found=0, match_vec=0, match_count=0.
- With X2_PREIMAGE_COUNT_EN, target=7'h00, mask=7'h20: done at T+1025, found=1, match_vec=10'd0, match_count=256.
- abort at T+5 during an unreachable-target scan: busy drops at the next edge, no done pulse. A new start is then accepted normally. Repeat the scan with rst_n pulsed mid-scan: outputs return to 0 asynchronously.
